// File: rtl/controlunit_multicycle_fsm_if.sv
// Control bundle between the multicycle main controller (master) and the datapath (slave).
// Carries the opcode and memory handshake inward and every select/enable outward.
interface controlunit_multicycle_fsm_if;
  logic [6:0] op;
  logic       mem_ready;
  logic       PCUpdate;
  logic       Branch;
  logic       IRWrite;
  logic       RegWrite;
  logic       MemWrite;
  logic       AdrSrc;
  logic [1:0] ResultSrc;
  logic [1:0] ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [1:0] ALUOp;
  logic [1:0] ImmSrc;
  logic       instr_done;
  logic       illegal_op;

  modport master (
    input  op, mem_ready,
    output PCUpdate, Branch, IRWrite, RegWrite, MemWrite, AdrSrc, ResultSrc,
           ALUSrcA, ALUSrcB, ALUOp, ImmSrc, instr_done, illegal_op
  );

  modport slave (
    output op, mem_ready,
    input  PCUpdate, Branch, IRWrite, RegWrite, MemWrite, AdrSrc, ResultSrc,
           ALUSrcA, ALUSrcB, ALUOp, ImmSrc, instr_done, illegal_op
  );
endinterface

// File: rtl/controlunit_multicycle_fsm.sv
// RV32I multicycle main controller: Moore FSM sequencing fetch/decode/execute/memory/writeback.
// Define MEM_WAIT_EN to stall FETCH, MEMREAD and MEMWRITE on the mem_ready handshake.
module controlunit_multicycle_fsm (
  input  logic                           clk,
  input  logic                           reset,
  controlunit_multicycle_fsm_if.master   bus
);

  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_BEQ  = 7'b1100011;

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE,
    S_EXECUTER, S_EXECUTEI, S_JAL, S_ALUWB, S_BEQ
  } state_e;

  typedef struct packed {
    logic       pc_update;
    logic       branch;
    logic       ir_write;
    logic       reg_write;
    logic       mem_write;
    logic       adr_src;
    logic [1:0] result_src;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
  } ctl_t;

  // Reset value: FETCH selects with both write enables held off.
  localparam ctl_t CTL_RESET = '{pc_update: 1'b0, branch: 1'b0, ir_write: 1'b0,
                                 reg_write: 1'b0, mem_write: 1'b0, adr_src: 1'b0,
                                 result_src: 2'b10, alu_src_a: 2'b00,
                                 alu_src_b: 2'b10, alu_op: 2'b00};

  state_e state_q, state_d;
  ctl_t   ctl_q, ctl_d;
  logic   run_q;
  logic   ready;
  logic   op_known;

`ifdef MEM_WAIT_EN
  assign ready = bus.mem_ready;
`else
  logic unused_mem_ready;
  assign unused_mem_ready = bus.mem_ready;
  assign ready            = 1'b1;
`endif

  assign op_known = (bus.op == OP_LW) || (bus.op == OP_SW) || (bus.op == OP_R) ||
                    (bus.op == OP_I)  || (bus.op == OP_JAL) || (bus.op == OP_BEQ);

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    if (!run_q) begin
      state_d = S_FETCH;
    end else begin
      case (state_q)
        S_FETCH:    if (ready) state_d = S_DECODE;
        S_DECODE: begin
          case (bus.op)
            OP_LW, OP_SW: state_d = S_MEMADR;
            OP_R:         state_d = S_EXECUTER;
            OP_I:         state_d = S_EXECUTEI;
            OP_JAL:       state_d = S_JAL;
            OP_BEQ:       state_d = S_BEQ;
            default:      state_d = S_FETCH;
          endcase
        end
        S_MEMADR:   state_d = (bus.op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
        S_MEMREAD:  if (ready) state_d = S_MEMWB;
        S_MEMWRITE: if (ready) state_d = S_FETCH;
        S_EXECUTER, S_EXECUTEI, S_JAL: state_d = S_ALUWB;
        default:    state_d = S_FETCH;
      endcase
    end
  end

  // Outputs are decoded from the next state so they are registered alongside it.
  always_comb begin
    ctl_d = '0;
    case (state_d)
      S_FETCH: begin
        ctl_d.ir_write   = 1'b1;
        ctl_d.alu_src_b  = 2'b10;
        ctl_d.result_src = 2'b10;
        ctl_d.pc_update  = 1'b1;
      end
      S_DECODE:   begin ctl_d.alu_src_a = 2'b01; ctl_d.alu_src_b = 2'b01; end
      S_MEMADR:   begin ctl_d.alu_src_a = 2'b10; ctl_d.alu_src_b = 2'b01; end
      S_MEMREAD:  ctl_d.adr_src = 1'b1;
      S_MEMWB:    begin ctl_d.result_src = 2'b01; ctl_d.reg_write = 1'b1; end
      S_MEMWRITE: begin ctl_d.adr_src = 1'b1; ctl_d.mem_write = 1'b1; end
      S_EXECUTER: begin ctl_d.alu_src_a = 2'b10; ctl_d.alu_op = 2'b10; end
      S_EXECUTEI: begin
        ctl_d.alu_src_a = 2'b10;
        ctl_d.alu_src_b = 2'b01;
        ctl_d.alu_op    = 2'b10;
      end
      S_JAL: begin
        ctl_d.alu_src_a = 2'b01;
        ctl_d.alu_src_b = 2'b10;
        ctl_d.pc_update = 1'b1;
      end
      S_ALUWB:    ctl_d.reg_write = 1'b1;
      S_BEQ: begin
        ctl_d.alu_src_a = 2'b10;
        ctl_d.alu_op    = 2'b01;
        ctl_d.branch    = 1'b1;
      end
      default:    ctl_d = '0;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_FETCH;
      run_q   <= 1'b0;
      ctl_q   <= CTL_RESET;
    end else begin
      state_q <= state_d;
      run_q   <= 1'b1;
      ctl_q   <= ctl_d;
    end
  end

  // A stalled fetch must not advance PC or reload IR until memory answers.
  assign bus.PCUpdate   = ctl_q.pc_update & ((state_q != S_FETCH) | ready);
  assign bus.IRWrite    = ctl_q.ir_write  & ((state_q != S_FETCH) | ready);
  assign bus.Branch     = ctl_q.branch;
  assign bus.RegWrite   = ctl_q.reg_write;
  assign bus.MemWrite   = ctl_q.mem_write;
  assign bus.AdrSrc     = ctl_q.adr_src;
  assign bus.ResultSrc  = ctl_q.result_src;
  assign bus.ALUSrcA    = ctl_q.alu_src_a;
  assign bus.ALUSrcB    = ctl_q.alu_src_b;
  assign bus.ALUOp      = ctl_q.alu_op;

  assign bus.illegal_op = (state_q == S_DECODE) && !op_known;
  assign bus.instr_done = (state_q == S_MEMWB) || (state_q == S_ALUWB) || (state_q == S_BEQ) ||
                          ((state_q == S_MEMWRITE) && ready) || bus.illegal_op;

  always_comb begin
    case (bus.op)
      OP_SW:   bus.ImmSrc = 2'b01;
      OP_BEQ:  bus.ImmSrc = 2'b10;
      OP_JAL:  bus.ImmSrc = 2'b11;
      default: bus.ImmSrc = 2'b00;
    endcase
  end

endmodule

// File: tb/tb_controlunit_multicycle_fsm.sv
// Directed bench for controlunit_multicycle_fsm: per-cycle control words checked against hand-written values.
module tb_controlunit_multicycle_fsm;

  // Control word: {PCUpdate, Branch, IRWrite, RegWrite, MemWrite, AdrSrc, ResultSrc,
  //                ALUSrcA, ALUSrcB, ALUOp, instr_done, illegal_op}
  localparam logic [15:0] E_RESET    = 16'h0220;
  localparam logic [15:0] E_FETCH    = 16'hA220;
  localparam logic [15:0] E_DECODE   = 16'h0050;
  localparam logic [15:0] E_ILLEGAL  = 16'h0053;
  localparam logic [15:0] E_MEMADR   = 16'h0090;
  localparam logic [15:0] E_MEMREAD  = 16'h0400;
  localparam logic [15:0] E_MEMWB    = 16'h1102;
  localparam logic [15:0] E_MEMWRITE = 16'h0C02;
  localparam logic [15:0] E_EXECR    = 16'h0088;
  localparam logic [15:0] E_EXECI    = 16'h0098;
  localparam logic [15:0] E_JAL      = 16'h8060;
  localparam logic [15:0] E_ALUWB    = 16'h1002;
  localparam logic [15:0] E_BEQ      = 16'h4086;

  logic clk = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_pass   = 0;

  controlunit_multicycle_fsm_if bus ();

  controlunit_multicycle_fsm dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.master)
  );

  always #5 clk = ~clk;

  logic [15:0] obs;
  assign obs = {bus.PCUpdate, bus.Branch, bus.IRWrite, bus.RegWrite, bus.MemWrite, bus.AdrSrc,
                bus.ResultSrc, bus.ALUSrcA, bus.ALUSrcB, bus.ALUOp, bus.instr_done, bus.illegal_op};

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // Called at a negedge in the instruction's FETCH cycle; leaves the bench in the next FETCH.
  task automatic run_instr(input string name, input logic [6:0] opc, input logic [1:0] imm,
                           input int n, input logic [0:5][15:0] exp);
    bus.op = opc;
    for (int c = 0; c < n; c++) begin
      #1;
      check($sformatf("%s cyc%0d ctl", name, c + 1), obs, exp[c]);
      check($sformatf("%s cyc%0d imm", name, c + 1), {14'd0, bus.ImmSrc}, {14'd0, imm});
      @(negedge clk);
    end
  endtask

  initial begin
    reset         = 1'b1;
    bus.op        = 7'b0000000;
    bus.mem_ready = 1'b1;

    @(negedge clk);
    check("reset hold", obs, E_RESET);
    @(negedge clk);
    check("reset hold 2", obs, E_RESET);
    reset = 1'b0;
    #1 check("just released", obs, E_RESET);
    @(negedge clk);

    run_instr("lw",   7'b0000011, 2'b00, 5, {E_FETCH, E_DECODE, E_MEMADR, E_MEMREAD, E_MEMWB, 16'h0});
    run_instr("sw",   7'b0100011, 2'b01, 4, {E_FETCH, E_DECODE, E_MEMADR, E_MEMWRITE, 16'h0, 16'h0});
    run_instr("rtyp", 7'b0110011, 2'b00, 4, {E_FETCH, E_DECODE, E_EXECR, E_ALUWB, 16'h0, 16'h0});
    run_instr("addi", 7'b0010011, 2'b00, 4, {E_FETCH, E_DECODE, E_EXECI, E_ALUWB, 16'h0, 16'h0});
    run_instr("jal",  7'b1101111, 2'b11, 4, {E_FETCH, E_DECODE, E_JAL, E_ALUWB, 16'h0, 16'h0});
    run_instr("beq",  7'b1100011, 2'b10, 3, {E_FETCH, E_DECODE, E_BEQ, 16'h0, 16'h0, 16'h0});
    run_instr("ill",  7'b1111111, 2'b00, 2, {E_FETCH, E_ILLEGAL, 16'h0, 16'h0, 16'h0, 16'h0});
    run_instr("lw2",  7'b0000011, 2'b00, 5, {E_FETCH, E_DECODE, E_MEMADR, E_MEMREAD, E_MEMWB, 16'h0});

    // Abort a load in its writeback cycle.
    bus.op = 7'b0000011;
    repeat (4) @(negedge clk);
    #1 check("abort lw in MEMWB", obs, E_MEMWB);
    reset = 1'b1;
    #1 check("abort lw async", obs, E_RESET);
    @(negedge clk);
    check("abort lw held", obs, E_RESET);
    reset = 1'b0;
    @(negedge clk);
    run_instr("post-abort beq", 7'b1100011, 2'b10, 3, {E_FETCH, E_DECODE, E_BEQ, 16'h0, 16'h0, 16'h0});

`ifdef MEM_WAIT_EN
    begin
      logic [0:9][15:0] w_exp;
      logic [0:9]       w_rdy;
      w_exp = {E_RESET, E_RESET, E_RESET, E_FETCH, E_DECODE, E_MEMADR,
               E_MEMREAD, E_MEMREAD, E_MEMREAD, E_MEMWB};
      w_rdy = 10'b0001110011;
      bus.op = 7'b0000011;
      for (int c = 0; c < 10; c++) begin
        bus.mem_ready = w_rdy[c];
        #1 check($sformatf("wait lw cyc%0d", c + 1), obs, w_exp[c]);
        @(negedge clk);
      end
      bus.mem_ready = 1'b1;
      #1 check("wait lw back to fetch", obs, E_FETCH);
    end
`endif

    // Abort a store in its write cycle.
    bus.op = 7'b0100011;
    repeat (3) @(negedge clk);
    #1 check("abort sw in MEMWRITE", obs, E_MEMWRITE);
    reset = 1'b1;
    #1 check("abort sw async", obs, E_RESET);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    #1 check("post-abort fetch", obs, E_FETCH);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
